// File: rtl/regfile_wb_pkg.sv
// Shared constants for the write-back register file slice.
package regfile_wb_pkg;

  localparam int unsigned RegNum       = 32;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        ReadEnable   = 1'b1;
  localparam logic        ReadDisable  = 1'b0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: counts issued-but-not-written-back results.
// Optional macro REGFILE_WB_BYPASS_EN: busy drops in the cycle the last pending write lands.
module reg_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic              issue_in,
  input  logic [ADDR_W-1:0] issue_addr_in,
  input  logic              flush_in,
  input  logic              re1_in,
  input  logic [ADDR_W-1:0] raddr1_in,
  input  logic              re2_in,
  input  logic [ADDR_W-1:0] raddr2_in,
  output logic              busy1_out,
  output logic              busy2_out,
  output logic              issue_full_out
);

  localparam int NumRegs = 1 << ADDR_W;

  logic [PEND_W-1:0] cnt_q [NumRegs];
  logic [PEND_W-1:0] cnt_d [NumRegs];
  logic              inc;
  logic              dec;

  // Issue/retire qualification and saturation decode.
  always_comb begin
    issue_full_out = (issue_addr_in != '0) && (cnt_q[issue_addr_in] == {PEND_W{1'b1}});
    inc = issue_in && (issue_addr_in != '0) && !issue_full_out;
    dec = (we_in == WriteEnable) && (waddr_in != '0) && (cnt_q[waddr_in] != '0);
  end

  // Next counter values; flush wins over everything and absorbs later decrements.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_in) begin
      for (int i = 0; i < NumRegs; i++) cnt_d[i] = '0;
    end else if (!(inc && dec && (issue_addr_in == waddr_in))) begin
      if (inc) cnt_d[issue_addr_in] = cnt_q[issue_addr_in] + PEND_W'(1);
      if (dec) cnt_d[waddr_in] = cnt_q[waddr_in] - PEND_W'(1);
    end
    cnt_d[0] = '0;
  end

  // Counter array; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NumRegs; i++) cnt_q[i] <= '0;
    end else if (rdy_in) begin
      cnt_q <= cnt_d;
    end
  end

  // Busy decode for the two ID read ports.
  always_comb begin
    busy1_out = (re1_in == ReadEnable) && (raddr1_in != '0) && (cnt_q[raddr1_in] != '0);
    busy2_out = (re2_in == ReadEnable) && (raddr2_in != '0) && (cnt_q[raddr2_in] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    if (dec && (waddr_in == raddr1_in) && (cnt_q[raddr1_in] == PEND_W'(1))) busy1_out = 1'b0;
    if (dec && (waddr_in == raddr2_in) && (cnt_q[raddr2_in] == PEND_W'(1))) busy2_out = 1'b0;
`endif
  end

endmodule

// File: rtl/regfile_wb.sv
// Integer register file: write-back sink, two ID read ports, RAW scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              re1_in,
  input  logic [ADDR_W-1:0] raddr1_in,
  output logic [DATA_W-1:0] rdata1_out,
  output logic              busy1_out,
  input  logic              re2_in,
  input  logic [ADDR_W-1:0] raddr2_in,
  output logic [DATA_W-1:0] rdata2_out,
  output logic              busy2_out,
  input  logic              issue_in,
  input  logic [ADDR_W-1:0] issue_addr_in,
  output logic              issue_full_out,
  input  logic              flush_in
);

  localparam int NumRegs = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];

  // Data array write; x0 is never written so it stays zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (rdy_in && (we_in == WriteEnable) && (waddr_in != '0)) begin
      regs_q[waddr_in] <= wdata_in;
    end
  end

  // Combinational read muxes; disabled ports and x0 read zero.
  always_comb begin
    rdata1_out = '0;
    rdata2_out = '0;
    if ((re1_in == ReadEnable) && (raddr1_in != '0)) rdata1_out = regs_q[raddr1_in];
    if ((re2_in == ReadEnable) && (raddr2_in != '0)) rdata2_out = regs_q[raddr2_in];
`ifdef REGFILE_WB_BYPASS_EN
    if ((re1_in == ReadEnable) && (raddr1_in != '0) && we_in && (waddr_in == raddr1_in)) begin
      rdata1_out = wdata_in;
    end
    if ((re2_in == ReadEnable) && (raddr2_in != '0) && we_in && (waddr_in == raddr2_in)) begin
      rdata2_out = wdata_in;
    end
`endif
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W),
    .PEND_W(PEND_W)
  ) u_scoreboard (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .we_in         (we_in),
    .waddr_in      (waddr_in),
    .issue_in      (issue_in),
    .issue_addr_in (issue_addr_in),
    .flush_in      (flush_in),
    .re1_in        (re1_in),
    .raddr1_in     (raddr1_in),
    .re2_in        (re2_in),
    .raddr2_in     (raddr2_in),
    .busy1_out     (busy1_out),
    .busy2_out     (busy2_out),
    .issue_full_out(issue_full_out)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb.
module tb_regfile_wb;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        we_in = 1'b0;
  logic [4:0]  waddr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        re1_in = 1'b0;
  logic [4:0]  raddr1_in = '0;
  logic [31:0] rdata1_out;
  logic        busy1_out;
  logic        re2_in = 1'b0;
  logic [4:0]  raddr2_in = '0;
  logic [31:0] rdata2_out;
  logic        busy2_out;
  logic        issue_in = 1'b0;
  logic [4:0]  issue_addr_in = '0;
  logic        issue_full_out;
  logic        flush_in = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  regfile_wb #(
    .DATA_W(32),
    .ADDR_W(5),
    .PEND_W(2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .we_in         (we_in),
    .waddr_in      (waddr_in),
    .wdata_in      (wdata_in),
    .re1_in        (re1_in),
    .raddr1_in     (raddr1_in),
    .rdata1_out    (rdata1_out),
    .busy1_out     (busy1_out),
    .re2_in        (re2_in),
    .raddr2_in     (raddr2_in),
    .rdata2_out    (rdata2_out),
    .busy2_out     (busy2_out),
    .issue_in      (issue_in),
    .issue_addr_in (issue_addr_in),
    .issue_full_out(issue_full_out),
    .flush_in      (flush_in)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    we_in = 1'b0; waddr_in = '0; wdata_in = '0;
    issue_in = 1'b0; issue_addr_in = '0; flush_in = 1'b0;
  endtask

  task automatic test_reset();
    re1_in = 1'b1; raddr1_in = 5'd5; issue_addr_in = 5'd3;
    #1;
    checks++;
    if (rdata1_out !== 32'h0) begin
      errors++; $display("FAIL reset_rdata1 got %h want %h", rdata1_out, 32'h0);
    end
    checks++;
    if (busy1_out !== 1'b0 || issue_full_out !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b full=%b want 0 0", busy1_out, issue_full_out);
    end
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    we_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'h1234;
    issue_in = 1'b1; issue_addr_in = 5'd5;
    tick();
    idle();
    re1_in = 1'b1; raddr1_in = 5'd5;
    #1;
    checks++;
    if (rdata1_out !== 32'h1234 || busy1_out !== 1'b1) begin
      errors++;
      $display("FAIL prereset_x5 got %h busy=%b want 00001234 busy=1", rdata1_out, busy1_out);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (rdata1_out !== 32'h0 || busy1_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_x5 got %h busy=%b want 00000000 busy=0", rdata1_out, busy1_out);
    end
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_x0();
    we_in = 1'b1; waddr_in = 5'd0; wdata_in = 32'hFFFF_FFFF;
    issue_in = 1'b1; issue_addr_in = 5'd0;
    tick();
    idle();
    re1_in = 1'b1; raddr1_in = 5'd0; re2_in = 1'b1; raddr2_in = 5'd0;
    #1;
    checks++;
    if (rdata1_out !== 32'h0 || rdata2_out !== 32'h0) begin
      errors++; $display("FAIL x0_read got %h %h want 0 0", rdata1_out, rdata2_out);
    end
    checks++;
    if (busy1_out !== 1'b0 || issue_full_out !== 1'b0) begin
      errors++; $display("FAIL x0_pending got busy=%b full=%b want 0 0", busy1_out, issue_full_out);
    end
  endtask

  task automatic test_same_cycle();
    we_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h1111_1111;
    tick();
    wdata_in = 32'hDEAD_BEEF;
    re2_in = 1'b1; raddr2_in = 5'd7;
    #1;
    checks++;
`ifdef REGFILE_WB_BYPASS_EN
    if (rdata2_out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_x7 got %h want deadbeef", rdata2_out);
    end
`else
    if (rdata2_out !== 32'h1111_1111) begin
      errors++; $display("FAIL nobypass_x7 got %h want 11111111", rdata2_out);
    end
`endif
    tick();
    idle();
    #1;
    checks++;
    if (rdata2_out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL x7_after got %h want deadbeef", rdata2_out);
    end
    re2_in = 1'b0;
    #1;
    checks++;
    if (rdata2_out !== 32'h0) begin
      errors++; $display("FAIL re2_disabled got %h want 0", rdata2_out);
    end
  endtask

  task automatic test_saturation();
    re1_in = 1'b1; raddr1_in = 5'd3;
    issue_in = 1'b1; issue_addr_in = 5'd3;
    repeat (3) tick();
    checks++;
    if (issue_full_out !== 1'b1 || busy1_out !== 1'b1) begin
      errors++; $display("FAIL sat_full got full=%b busy=%b want 1 1", issue_full_out, busy1_out);
    end
    tick();  // 4th issue must be blocked
    issue_in = 1'b0;
    we_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'h33;
    tick();
    checks++;
    if (issue_full_out !== 1'b0 || busy1_out !== 1'b1) begin
      errors++;
      $display("FAIL sat_after_wb1 got full=%b busy=%b want 0 1", issue_full_out, busy1_out);
    end
    tick();
    #1;
    checks++;
`ifdef REGFILE_WB_BYPASS_EN
    if (busy1_out !== 1'b0) begin
      errors++; $display("FAIL sat_last_wb_busy got %b want 0", busy1_out);
    end
`else
    if (busy1_out !== 1'b1) begin
      errors++; $display("FAIL sat_last_wb_busy got %b want 1", busy1_out);
    end
`endif
    tick();
    idle();
    #1;
    checks++;
    if (busy1_out !== 1'b0) begin
      errors++; $display("FAIL sat_drained got busy=%b want 0", busy1_out);
    end
  endtask

  task automatic test_simultaneous();
    re1_in = 1'b1; raddr1_in = 5'd9; re2_in = 1'b1; raddr2_in = 5'd12;
    issue_in = 1'b1; issue_addr_in = 5'd9;
    tick();
    we_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'h99;
    tick();
    idle();
    #1;
    checks++;
    if (busy1_out !== 1'b1) begin
      errors++; $display("FAIL same_reg_inc_dec got busy9=%b want 1", busy1_out);
    end
    issue_in = 1'b1; issue_addr_in = 5'd12;
    we_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'h98;
    tick();
    idle();
    #1;
    checks++;
    if (busy1_out !== 1'b0 || busy2_out !== 1'b1) begin
      errors++; $display("FAIL diff_reg got busy9=%b busy12=%b want 0 1", busy1_out, busy2_out);
    end
    raddr1_in = 5'd4;
    issue_in = 1'b1; issue_addr_in = 5'd4;
    tick();
    flush_in = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (busy1_out !== 1'b0 || busy2_out !== 1'b0) begin
      errors++; $display("FAIL flush got busy4=%b busy12=%b want 0 0", busy1_out, busy2_out);
    end
    we_in = 1'b1; waddr_in = 5'd4; wdata_in = 32'hABCD;
    tick();
    idle();
    issue_addr_in = 5'd4;
    #1;
    checks++;
    if (rdata1_out !== 32'hABCD || busy1_out !== 1'b0 || issue_full_out !== 1'b0) begin
      errors++;
      $display("FAIL wb_after_flush got %h busy=%b full=%b want 0000abcd 0 0",
               rdata1_out, busy1_out, issue_full_out);
    end
  endtask

  task automatic test_rdy_hold();
    rdy_in = 1'b0;
    we_in = 1'b1; waddr_in = 5'd10; wdata_in = 32'h55;
    issue_in = 1'b1; issue_addr_in = 5'd11;
    tick();
    idle();
    re1_in = 1'b1; raddr1_in = 5'd10; re2_in = 1'b1; raddr2_in = 5'd11;
    #1;
    checks++;
    if (rdata1_out !== 32'h0 || busy2_out !== 1'b0) begin
      errors++; $display("FAIL rdy_hold got x10=%h busy11=%b want 0 0", rdata1_out, busy2_out);
    end
    rdy_in = 1'b1;
    we_in = 1'b1; waddr_in = 5'd10; wdata_in = 32'h55;
    issue_in = 1'b1; issue_addr_in = 5'd11;
    tick();
    idle();
    #1;
    checks++;
    if (rdata1_out !== 32'h55 || busy2_out !== 1'b1) begin
      errors++; $display("FAIL rdy_resume got x10=%h busy11=%b want 55 1", rdata1_out, busy2_out);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_x0();
    test_same_cycle();
    test_saturation();
    test_simultaneous();
    test_rdy_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
